// File: rtl/spi_pkg.sv
// Shared types and constants for the mode-0 SPI master.
package spi_pkg;

  localparam int unsigned SPI_WIDTH       = 8;
  localparam int unsigned SPI_CNT_W       = 8;
  localparam int unsigned SPI_BIT_W       = 3;
  localparam int unsigned SPI_MIN_CLK_DIV = 6;
  localparam int unsigned SPI_MIN_CS      = 1;
  localparam int unsigned SPI_MAX_PARAM   = 255;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    HIGH,
    LOW,
    HOLD,
    GAP
  } spi_state_e;

  // True when a timing parameter fits the 8-bit phase counter and its floor.
  function automatic logic param_ok(input int unsigned value, input int unsigned min_value);
    return (value >= min_value) && (value <= SPI_MAX_PARAM);
  endfunction

endpackage

// File: rtl/spi_master_if.sv
// Fabric handshake plus SPI pins of the master, grouped as one bundle.
interface spi_master_if;
  import spi_pkg::*;

  logic                 start;
  logic [SPI_WIDTH-1:0] tx_data;
  logic                 busy;
  logic                 done;
  logic [SPI_WIDTH-1:0] rx_data;
  logic                 spi_clk;
  logic                 spi_cs;
  logic                 mosi;
  logic                 miso;

  modport master (
    input  start, tx_data, miso,
    output busy, done, rx_data, spi_clk, spi_cs, mosi
  );

  modport slave (
    output start, tx_data, miso,
    input  busy, done, rx_data, spi_clk, spi_cs, mosi
  );

endinterface

// File: rtl/spi_phase_timer.sv
// Loadable down-counter shared by every timed phase of the SPI frame.
module spi_phase_timer
  import spi_pkg::*;
(
  input  logic                 system_clk,
  input  logic                 system_rst_n,
  input  logic                 load,
  input  logic [SPI_CNT_W-1:0] load_val,
  output logic                 tc_c
);

  logic [SPI_CNT_W-1:0] count;

  // Saturates at zero so a phase that is not reloaded simply waits.
  always_ff @(posedge system_clk or negedge system_rst_n) begin
    if (!system_rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - SPI_CNT_W'(1);
    end
  end

  assign tc_c = (count == '0);

endmodule

// File: rtl/spi_master.sv
// Mode-0 SPI master: one MSB-first byte exchanged per chip-select window.
module spi_master
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 16,
  parameter int unsigned CS_SETUP = 4,
  parameter int unsigned CS_HOLD  = 4,
  parameter int unsigned CS_IDLE  = 8
) (
  input logic          system_clk,
  input logic          system_rst_n,
  spi_master_if.master bus
);

  if (!param_ok(CLK_DIV, SPI_MIN_CLK_DIV)) begin : g_bad_clk_div
    $error("spi_master: CLK_DIV must be 6..255");
  end
  if (!param_ok(CS_SETUP, SPI_MIN_CS)) begin : g_bad_cs_setup
    $error("spi_master: CS_SETUP must be 1..255");
  end
  if (!param_ok(CS_HOLD, SPI_MIN_CS)) begin : g_bad_cs_hold
    $error("spi_master: CS_HOLD must be 1..255");
  end
  if (!param_ok(CS_IDLE, SPI_MIN_CS)) begin : g_bad_cs_idle
    $error("spi_master: CS_IDLE must be 1..255");
  end

  localparam logic [SPI_CNT_W-1:0] DIV_LD   = SPI_CNT_W'(CLK_DIV - 1);
  localparam logic [SPI_CNT_W-1:0] SETUP_LD = SPI_CNT_W'(CS_SETUP - 1);
  localparam logic [SPI_CNT_W-1:0] HOLD_LD  = SPI_CNT_W'(CS_HOLD - 1);
  localparam logic [SPI_CNT_W-1:0] IDLE_LD  = SPI_CNT_W'(CS_IDLE - 1);
  localparam logic [SPI_BIT_W-1:0] LAST_BIT = SPI_BIT_W'(SPI_WIDTH - 1);

  spi_state_e           state;
  spi_state_e           state_nxt;
  logic                 tmr_load_c;
  logic [SPI_CNT_W-1:0] tmr_val_c;
  logic                 tmr_tc_c;
  logic                 accept_c;
  logic                 rise_c;
  logic                 fall_c;
  logic                 cs_off_c;
  logic                 gap_end_c;

  logic [SPI_WIDTH-1:0] tx_sh;
  logic [SPI_WIDTH-1:0] rx_sh;
  logic [SPI_BIT_W-1:0] bit_cnt;
  logic                 busy;
  logic                 done;
  logic [SPI_WIDTH-1:0] rx_data;
  logic                 spi_clk;
  logic                 spi_cs;
  logic                 mosi;

  spi_phase_timer u_timer (
    .system_clk   (system_clk),
    .system_rst_n (system_rst_n),
    .load         (tmr_load_c),
    .load_val     (tmr_val_c),
    .tc_c         (tmr_tc_c)
  );

  always_ff @(posedge system_clk or negedge system_rst_n) begin
    if (!system_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, timer reload and one-cycle edge strobes for the datapath.
  always_comb begin
    state_nxt  = state;
    tmr_load_c = 1'b0;
    tmr_val_c  = '0;
    accept_c   = 1'b0;
    rise_c     = 1'b0;
    fall_c     = 1'b0;
    cs_off_c   = 1'b0;
    gap_end_c  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept_c   = 1'b1;
          tmr_load_c = 1'b1;
          tmr_val_c  = SETUP_LD;
          state_nxt  = SETUP;
        end
      end
      SETUP, LOW: begin
        if (tmr_tc_c) begin
          rise_c     = 1'b1;
          tmr_load_c = 1'b1;
          tmr_val_c  = DIV_LD;
          state_nxt  = HIGH;
        end
      end
      HIGH: begin
        if (tmr_tc_c) begin
          fall_c     = 1'b1;
          tmr_load_c = 1'b1;
          // The eighth falling edge closes the frame instead of opening another low phase.
          if (bit_cnt == LAST_BIT) begin
            tmr_val_c = HOLD_LD;
            state_nxt = HOLD;
          end else begin
            tmr_val_c = DIV_LD;
            state_nxt = LOW;
          end
        end
      end
      HOLD: begin
        if (tmr_tc_c) begin
          cs_off_c   = 1'b1;
          tmr_load_c = 1'b1;
          tmr_val_c  = IDLE_LD;
          state_nxt  = GAP;
        end
      end
      GAP: begin
        if (tmr_tc_c) begin
          gap_end_c = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Shift registers and pin flops; every pin comes straight from a flop.
  always_ff @(posedge system_clk or negedge system_rst_n) begin
    if (!system_rst_n) begin
      tx_sh   <= '0;
      rx_sh   <= '0;
      bit_cnt <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rx_data <= '0;
      spi_clk <= 1'b0;
      spi_cs  <= 1'b1;
      mosi    <= 1'b0;
    end else begin
      done <= cs_off_c;
      if (accept_c) begin
        tx_sh   <= bus.tx_data;
        bit_cnt <= '0;
        busy    <= 1'b1;
        spi_cs  <= 1'b0;
        mosi    <= bus.tx_data[SPI_WIDTH-1];
      end
      // miso is held stable by the slave well around the edge, so no synchroniser.
      if (rise_c) begin
        spi_clk <= 1'b1;
        rx_sh   <= {rx_sh[SPI_WIDTH-2:0], bus.miso};
      end
      if (fall_c) begin
        spi_clk <= 1'b0;
        tx_sh   <= {tx_sh[SPI_WIDTH-2:0], 1'b0};
        mosi    <= (bit_cnt == LAST_BIT) ? 1'b0 : tx_sh[SPI_WIDTH-2];
        bit_cnt <= bit_cnt + SPI_BIT_W'(1);
      end
      if (cs_off_c) begin
        spi_cs  <= 1'b1;
        rx_data <= rx_sh;
      end
      if (gap_end_c) begin
        busy <= 1'b0;
      end
    end
  end

  assign bus.busy    = busy;
  assign bus.done    = done;
  assign bus.rx_data = rx_data;
  assign bus.spi_clk = spi_clk;
  assign bus.spi_cs  = spi_cs;
  assign bus.mosi    = mosi;

endmodule

// File: tb/tb_spi_master.sv
// Directed and randomised frames against two spi_master instances (CLK_DIV 16 and 6).
module tb_spi_master;
  import spi_pkg::*;

  localparam int unsigned D0 = 16;
  localparam int unsigned D1 = 6;
  localparam int unsigned S  = 4;
  localparam int unsigned H  = 4;
  localparam int unsigned I  = 8;

  logic system_clk   = 1'b0;
  logic system_rst_n = 1'b0;
  always #5 system_clk = ~system_clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge system_clk) cyc <= cyc + 1;

  spi_master_if if0 ();
  spi_master_if if1 ();

  spi_master #(.CLK_DIV(D0), .CS_SETUP(S), .CS_HOLD(H), .CS_IDLE(I)) u_dut0 (
    .system_clk   (system_clk),
    .system_rst_n (system_rst_n),
    .bus          (if0)
  );

  spi_master #(.CLK_DIV(D1), .CS_SETUP(S), .CS_HOLD(H), .CS_IDLE(I)) u_dut1 (
    .system_clk   (system_clk),
    .system_rst_n (system_rst_n),
    .bus          (if1)
  );

  // Slave 0: ideal mode-0 slave (next bit after each falling edge) or mosi loopback.
  logic       loop0  = 1'b0;
  logic [7:0] sbyte0 = 8'h00;
  logic [7:0] ssh0   = 8'h00;
  logic       psclk0 = 1'b0;
  always @(negedge system_clk) begin
    psclk0 <= if0.spi_clk;
    if (if0.spi_cs) ssh0 <= sbyte0;
    else if (psclk0 && !if0.spi_clk) ssh0 <= {ssh0[6:0], 1'b0};
  end
  assign if0.miso = loop0 ? if0.mosi : ssh0[7];

  // Bus monitor for DUT0: done pulses, bits seen at each SCLK rise, phase widths.
  int         done_cnt  = 0;
  int         rise_cnt  = 0;
  int         unstable  = 0;
  int         bad_width = 0;
  int         last_edge = 0;
  logic       pclk_m    = 1'b0;
  logic       pmosi     = 1'b0;
  logic       fall_seen = 1'b0;
  logic [7:0] mosi_sh   = 8'h00;
  always @(negedge system_clk) begin
    pclk_m <= if0.spi_clk;
    pmosi  <= if0.mosi;
    if (if0.done) done_cnt <= done_cnt + 1;
    if (system_rst_n) begin
      if (!pclk_m && if0.spi_clk) begin
        rise_cnt <= rise_cnt + 1;
        mosi_sh  <= {mosi_sh[6:0], if0.mosi};
        if (if0.mosi !== pmosi) unstable <= unstable + 1;
        if (fall_seen && (cyc - last_edge) != int'(D0)) bad_width <= bad_width + 1;
        last_edge <= cyc;
      end
      if (pclk_m && !if0.spi_clk) begin
        if ((cyc - last_edge) != int'(D0)) bad_width <= bad_width + 1;
        last_edge <= cyc;
        fall_seen <= 1'b1;
      end
    end
    if (if0.spi_cs) fall_seen <= 1'b0;
  end

  // Slave 1: FPGA-style slave that sees SCLK and cs_n through 3-flop synchronisers.
  logic [2:0] sclk_s;
  logic [2:0] cs_s;
  logic [7:0] s1_tx, s1_rx, s1_received;
  logic [7:0] s1_data_to_send = 8'h00;
  logic [3:0] s1_bits;
  logic       s1_ready;
  always @(posedge system_clk or negedge system_rst_n) begin
    if (!system_rst_n) begin
      sclk_s <= 3'b000; cs_s <= 3'b111; s1_tx <= 8'h00; s1_rx <= 8'h00;
      s1_bits <= 4'd0; s1_received <= 8'h00; s1_ready <= 1'b0;
    end else begin
      sclk_s <= {sclk_s[1:0], if1.spi_clk};
      cs_s   <= {cs_s[1:0], if1.spi_cs};
      if (cs_s[1]) begin
        s1_tx   <= s1_data_to_send;
        s1_bits <= 4'd0;
        if (!cs_s[2] && s1_bits == 4'd8) begin
          s1_received <= s1_rx;
          s1_ready    <= 1'b1;
        end
      end else begin
        if (cs_s[2]) s1_ready <= 1'b0;
        if (sclk_s[1] && !sclk_s[2]) begin
          s1_rx   <= {s1_rx[6:0], if1.mosi};
          s1_bits <= s1_bits + 4'd1;
        end
        if (!sclk_s[1] && sclk_s[2]) s1_tx <= {s1_tx[6:0], 1'b0};
      end
    end
  end
  assign if1.miso = s1_tx[7];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle0();
    int n = 0;
    while (if0.busy !== 1'b0 && n < 1000) begin @(negedge system_clk); n++; end
  endtask

  // One DUT0 frame; expected rx is the slave byte, or tx itself under loopback.
  task automatic frame0(input logic [7:0] tx, input logic lp, input logic [7:0] sb,
                        input logic pulse, input string tag);
    int c0, cd, cb, n, d0, bw0, un0;
    logic [7:0] exp_rx;
    exp_rx = lp ? tx : sb;
    wait_idle0();
    loop0 = lp; sbyte0 = sb;
    @(negedge system_clk);
    d0 = done_cnt; bw0 = bad_width; un0 = unstable;
    if0.tx_data = tx; if0.start = 1'b1; c0 = cyc;
    @(negedge system_clk);
    if0.start = 1'b0; if0.tx_data = ~tx;
    chk({tag, ".busy_on"}, 32'(if0.busy), 32'd1);
    chk({tag, ".cs_low"}, 32'(if0.spi_cs), 32'd0);
    chk({tag, ".mosi_msb"}, 32'(if0.mosi), 32'(tx[7]));
    n = 0;
    while (if0.done !== 1'b1 && n < 2000) begin
      @(negedge system_clk); n++;
      if (pulse) begin
        if0.start   = ((cyc - c0) == 20) || ((cyc - c0) == 100);
        if0.tx_data = 8'hFF;
      end
    end
    if0.start = 1'b0;
    cd = cyc;
    chk({tag, ".latency"}, 32'(cd - c0), 32'(1 + S + 15 * D0 + H));
    chk({tag, ".rx_data"}, 32'(if0.rx_data), 32'(exp_rx));
    chk({tag, ".cs_high"}, 32'(if0.spi_cs), 32'd1);
    n = 0;
    while (if0.busy !== 1'b0 && n < 1000) begin @(negedge system_clk); n++; end
    cb = cyc;
    chk({tag, ".gap"}, 32'(cb - cd), 32'(I));
    chk({tag, ".done_cnt"}, 32'(done_cnt - d0), 32'd1);
    chk({tag, ".mosi_bits"}, 32'(mosi_sh), 32'(tx));
    chk({tag, ".sclk_width"}, 32'(bad_width - bw0), 32'd0);
    chk({tag, ".mosi_stable"}, 32'(unstable - un0), 32'd0);
  endtask

  task automatic frame1(input logic [7:0] tx, input logic [7:0] sb, input string tag);
    int c0, n;
    n = 0;
    while (if1.busy !== 1'b0 && n < 1000) begin @(negedge system_clk); n++; end
    s1_data_to_send = sb;
    repeat (4) @(negedge system_clk);
    if1.tx_data = tx; if1.start = 1'b1; c0 = cyc;
    @(negedge system_clk);
    if1.start = 1'b0; if1.tx_data = 8'h00;
    n = 0;
    while (if1.done !== 1'b1 && n < 1000) begin @(negedge system_clk); n++; end
    chk({tag, ".latency"}, 32'(cyc - c0), 32'(1 + S + 15 * D1 + H));
    chk({tag, ".rx_data"}, 32'(if1.rx_data), 32'(sb));
    repeat (6) @(negedge system_clk);
    chk({tag, ".slave_rx"}, 32'(s1_received), 32'(tx));
    chk({tag, ".slave_ready"}, 32'(s1_ready), 32'd1);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, cd, cb, n, d0, r0;
    logic [7:0] tx;
    if0.start = 1'b0; if0.tx_data = 8'h00;
    if1.start = 1'b0; if1.tx_data = 8'h00;
    repeat (3) @(negedge system_clk);
    system_rst_n = 1'b1;
    repeat (50) @(negedge system_clk);
    chk("rst.cs", 32'(if0.spi_cs), 32'd1);
    chk("rst.sclk", 32'(if0.spi_clk), 32'd0);
    chk("rst.busy", 32'(if0.busy), 32'd0);
    chk("rst.rx_data", 32'(if0.rx_data), 32'd0);
    chk("rst.mosi", 32'(if0.mosi), 32'd0);
    chk("rst.no_done", 32'(done_cnt), 32'd0);

    frame0(8'hA5, 1'b0, 8'h3C, 1'b0, "a5_3c");

    // Back-to-back loopback with start held high across both frames.
    wait_idle0();
    loop0 = 1'b1;
    @(negedge system_clk);
    d0 = done_cnt;
    if0.tx_data = 8'h81; if0.start = 1'b1; c0 = cyc;
    n = 0;
    while (if0.done !== 1'b1 && n < 2000) begin @(negedge system_clk); n++; end
    cd = cyc;
    chk("b2b.latency1", 32'(cd - c0), 32'(1 + S + 15 * D0 + H));
    chk("b2b.rx1", 32'(if0.rx_data), 32'h81);
    if0.tx_data = 8'h7E;
    n = 0;
    while (if0.busy !== 1'b0 && n < 1000) begin @(negedge system_clk); n++; end
    cb = cyc;
    chk("b2b.gap", 32'(cb - cd), 32'(I));
    chk("b2b.mosi1", 32'(mosi_sh), 32'h81);
    @(negedge system_clk);
    chk("b2b.reaccept", 32'(if0.busy), 32'd1);
    chk("b2b.cs_low2", 32'(if0.spi_cs), 32'd0);
    chk("b2b.cs_high_len", 32'(cyc - cd), 32'(I + 1));
    if0.start = 1'b0;
    n = 0;
    while (if0.done !== 1'b1 && n < 2000) begin @(negedge system_clk); n++; end
    chk("b2b.latency2", 32'(cyc - cb), 32'(1 + S + 15 * D0 + H));
    chk("b2b.rx2", 32'(if0.rx_data), 32'h7E);
    wait_idle0();
    chk("b2b.mosi2", 32'(mosi_sh), 32'h7E);
    chk("b2b.done_cnt", 32'(done_cnt - d0), 32'd2);

    frame0(8'($urandom_range(0, 254)), 1'b0, 8'($urandom), 1'b1, "ignore_start");

    // Reset while SCLK is high during bit 4.
    wait_idle0();
    loop0 = 1'b0; sbyte0 = 8'($urandom);
    @(negedge system_clk);
    d0 = done_cnt; r0 = rise_cnt; tx = 8'($urandom);
    if0.tx_data = tx; if0.start = 1'b1;
    @(negedge system_clk);
    if0.start = 1'b0;
    n = 0;
    while (!((rise_cnt - r0) >= 5 && if0.spi_clk === 1'b1) && n < 1000) begin
      @(negedge system_clk); n++;
    end
    chk("mid_rst.sclk_high", 32'(if0.spi_clk), 32'd1);
    #2 system_rst_n = 1'b0;
    #1;
    chk("mid_rst.cs", 32'(if0.spi_cs), 32'd1);
    chk("mid_rst.sclk", 32'(if0.spi_clk), 32'd0);
    chk("mid_rst.busy", 32'(if0.busy), 32'd0);
    chk("mid_rst.done", 32'(if0.done), 32'd0);
    chk("mid_rst.rx_data", 32'(if0.rx_data), 32'd0);
    repeat (4) @(negedge system_clk);
    system_rst_n = 1'b1;
    repeat (20) @(negedge system_clk);
    chk("mid_rst.no_done", 32'(done_cnt - d0), 32'd0);
    chk("mid_rst.idle_cs", 32'(if0.spi_cs), 32'd1);
    frame0(8'h55, 1'b0, 8'($urandom), 1'b0, "post_rst");

    for (int k = 0; k < 3; k++) begin
      frame0(8'($urandom), 1'($urandom_range(0, 1)), 8'($urandom), 1'b0, "rand0");
    end

    frame1(8'hC3, 8'h5A, "div6");
    for (int k = 0; k < 2; k++) begin
      frame1(8'($urandom), 8'($urandom), "rand1");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
